// File: rtl/sprite_evaluator_if.sv
// Bundle between the sprite evaluator and its controller/OAM: line request,
// status, OAM read port and the resulting secondary array.
interface sprite_evaluator_if #(
  parameter int OAM_ADDR_SIZE     = 8,
  parameter int OAM_DATA_SIZE     = 32,
  parameter int SECOND_ARRAY_SIZE = 32,
  parameter int DISPLAY_HEIGHT    = 480,
  parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT)
) ();
  logic                                            start;
  logic [LINE_NUMBER_WIDTH-1:0]                    line_number;
  logic                                            busy;
  logic                                            done;
  logic [OAM_ADDR_SIZE-1:0]                        oam_a;
  logic [OAM_DATA_SIZE-1:0]                        oam_d;
  logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0]   second_array;
  logic [$clog2(SECOND_ARRAY_SIZE):0]              hit_count;
  logic                                            overflow;

  modport master (
    output start, line_number, oam_d,
    input  busy, done, oam_a, second_array, hit_count, overflow
  );

  modport slave (
    input  start, line_number, oam_d,
    output busy, done, oam_a, second_array, hit_count, overflow
  );
endinterface

// File: rtl/sprite_evaluator.sv
// Scans OAM for sprites covering one display line and collects their addresses.
// Optional macro SPRITE_EVAL_EARLY_STOP_EN: stop the scan at the first overflowing hit.
module sprite_evaluator #(
  parameter int OAM_ADDR_SIZE     = 8,
  parameter int OAM_DATA_SIZE     = 32,
  parameter int OAM_ENTRIES       = 256,
  parameter int SECOND_ARRAY_SIZE = 32,
  parameter int SPRITE_HEIGHT     = 16,
  parameter int DISPLAY_HEIGHT    = 480,
  parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  sprite_evaluator_if.slave bus
);
  localparam int HC_W   = $clog2(SECOND_ARRAY_SIZE) + 1;
  localparam int SLOT_W = OAM_ADDR_SIZE + 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_FLUSH, S_DONE} state_t;

  state_t                                  state_q, state_d;
  logic [LINE_NUMBER_WIDTH-1:0]            line_q, line_d;
  logic [OAM_ADDR_SIZE-1:0]                oam_a_q, oam_a_d;
  logic                                    vld_p1_q, vld_p1_d;
  logic [OAM_ADDR_SIZE-1:0]                addr_p1_q, addr_p1_d;
  logic [SECOND_ARRAY_SIZE-1:0][SLOT_W-1:0] slots_q, slots_d;
  logic [HC_W-1:0]                         hit_cnt_q, hit_cnt_d;
  logic                                    ovf_q, ovf_d;
  logic                                    hit, full;
  logic                                    unused_oam_bits;

  // 11-bit compare keeps ypos+SPRITE_HEIGHT from wrapping near the top of the ypos range.
  function automatic logic is_hit(input logic [OAM_DATA_SIZE-1:0] w,
                                  input logic [LINE_NUMBER_WIDTH-1:0] line);
    logic [10:0] y, l, top;
    y   = {1'b0, w[27:18]};
    l   = 11'(line);
    top = y + 11'(SPRITE_HEIGHT);
    return w[31] && (l >= y) && (l < top);
  endfunction

  assign unused_oam_bits = ^{bus.oam_d[30:28], bus.oam_d[17:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      oam_a_q   <= '0;
      vld_p1_q  <= 1'b0;
      addr_p1_q <= '0;
      slots_q   <= '0;
      hit_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      oam_a_q   <= oam_a_d;
      vld_p1_q  <= vld_p1_d;
      addr_p1_q <= addr_p1_d;
      slots_q   <= slots_d;
      hit_cnt_q <= hit_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    oam_a_d   = oam_a_q;
    vld_p1_d  = 1'b0;
    addr_p1_d = addr_p1_q;
    slots_d   = slots_q;
    hit_cnt_d = hit_cnt_q;
    ovf_d     = ovf_q;
    hit       = vld_p1_q && is_hit(bus.oam_d, line_q);
    full      = (hit_cnt_q == HC_W'(SECOND_ARRAY_SIZE));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          line_d  = bus.line_number;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        slots_d   = '0;
        hit_cnt_d = '0;
        ovf_d     = 1'b0;
        oam_a_d   = '0;
        state_d   = S_SCAN;
      end
      S_SCAN: begin
        vld_p1_d  = 1'b1;
        addr_p1_d = oam_a_q;
        if (oam_a_q == OAM_ADDR_SIZE'(OAM_ENTRIES - 1)) state_d = S_FLUSH;
        else                                            oam_a_d = oam_a_q + OAM_ADDR_SIZE'(1);
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Evaluation stage: word on oam_d belongs to addr_p1_q issued last cycle.
    if (hit) begin
      if (!full) begin
        slots_d[hit_cnt_q[HC_W-2:0]] = {addr_p1_q, 1'b1};
        hit_cnt_d = hit_cnt_q + HC_W'(1);
      end else begin
        ovf_d = 1'b1;
`ifdef SPRITE_EVAL_EARLY_STOP_EN
        state_d  = S_DONE;
        vld_p1_d = 1'b0;
`else
        state_d  = state_d;
`endif
      end
    end
  end

  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.oam_a        = oam_a_q;
  assign bus.second_array = slots_q;
  assign bus.hit_count    = hit_cnt_q;
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_sprite_evaluator.sv
// Directed bench for sprite_evaluator: OAM memory model, per-line reference
// result computed from the hit rule, and literal pins on the key scenarios.
module tb_sprite_evaluator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_evaluator_if bus ();
  sprite_evaluator dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [256];
  always @(posedge clk) bus.oam_d <= mem[bus.oam_a];

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;
  logic [31:0][8:0] exp_sa;
  int exp_hc;
  int exp_ovf;
  int lat;

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_sa(input string name, input logic [31:0][8:0] act,
                          input logic [31:0][8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic en, input int ypos);
    logic [9:0] y;
    y = ypos[9:0];
    return {en, 3'b101, y, 18'h2A5A5};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = word(1'b0, 100);
  endtask

  // Reference: every enabled entry whose 16-line span covers the line, in address order.
  task automatic model(input int line);
    int n;
    int y;
    n = 0;
    exp_sa = '0;
    for (int i = 0; i < 256; i++) begin
      y = int'(mem[i][27:18]);
      if (mem[i][31] && line >= y && line < y + 16) begin
        if (n < 32) exp_sa[n] = {i[7:0], 1'b1};
        n++;
      end
    end
    exp_hc  = (n > 32) ? 32 : n;
    exp_ovf = (n > 32) ? 1 : 0;
  endtask

  // Called at a negedge. lat counts the accepting edge as cycle 1.
  task automatic run_scan(input int line, input int pulse_at, output int l);
    chk_en = 1'b0;
    model(line);
    bus.start = 1'b1;
    bus.line_number = line[8:0];
    @(negedge clk);
    l = 1;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && l < 1000) begin
      if (l == pulse_at) begin
        bus.start = 1'b1;
        bus.line_number = 9'd300;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      l++;
    end
    bus.start = 1'b0;
    check_i("done_reached", int'(bus.done), 1);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en && bus.done) begin
      check_i("cmp_hit_count", int'(bus.hit_count), exp_hc);
      check_i("cmp_overflow", int'(bus.overflow), exp_ovf);
      check_sa("cmp_slots", bus.second_array, exp_sa);
      check_i("cmp_busy", int'(bus.busy), 0);
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.line_number = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_i("rst_busy", int'(bus.busy), 0);
    check_i("rst_done", int'(bus.done), 0);
    check_i("rst_oam_a", int'(bus.oam_a), 0);
    check_i("rst_hit_count", int'(bus.hit_count), 0);
    check_i("rst_overflow", int'(bus.overflow), 0);
    check_sa("rst_slots", bus.second_array, '0);
    rst = 1'b0;

    // All entries disabled
    run_scan(100, -1, lat);
    check_i("lat_empty", lat, 259);
    check_i("empty_slot0_valid", int'(bus.second_array[0][0]), 0);
    check_i("empty_hc", int'(bus.hit_count), 0);

    // Two hits, entry 9 via the 85+16 span
    mem[5] = word(1'b1, 100);
    mem[9] = word(1'b1, 85);
    run_scan(100, -1, lat);
    check_i("lat_two", lat, 259);
    check_i("two_slot0", int'(bus.second_array[0]), 'h00B);
    check_i("two_slot1", int'(bus.second_array[1]), 'h013);
    check_i("two_slot2", int'(bus.second_array[2]), 0);
    check_i("two_hc", int'(bus.hit_count), 2);

    // Upper bound exclusive
    clear_mem();
    mem[3] = word(1'b1, 100);
    run_scan(116, -1, lat);
    check_i("ub116_hc", int'(bus.hit_count), 0);
    run_scan(115, -1, lat);
    check_i("ub115_hc", int'(bus.hit_count), 1);
    check_i("ub115_slot0", int'(bus.second_array[0]), 'h007);

    // Overflow: 40 hits on line 0
    clear_mem();
    for (int i = 0; i < 40; i++) mem[i] = word(1'b1, 0);
    run_scan(0, -1, lat);
    check_i("ovf_hc", int'(bus.hit_count), 32);
    check_i("ovf_flag", int'(bus.overflow), 1);
    check_i("ovf_slot31", int'(bus.second_array[31]), 'h03F);
`ifdef SPRITE_EVAL_EARLY_STOP_EN
    check_i("ovf_lat_early", int'(lat < 259), 1);
`else
    check_i("ovf_lat_full", lat, 259);
`endif

    // No wrap at ypos=1020, plus a start pulse in the middle of SCAN
    clear_mem();
    mem[4] = word(1'b1, 1020);
    mem[7] = word(1'b1, 0);
    run_scan(2, 50, lat);
    check_i("wrap_lat", lat, 259);
    check_i("wrap_hc", int'(bus.hit_count), 1);
    check_i("wrap_slot0", int'(bus.second_array[0]), 'h00F);

    // Abort mid-scan, then restart on the first edge after release
    clear_mem();
    mem[5] = word(1'b1, 100);
    mem[9] = word(1'b1, 85);
    chk_en = 1'b0;
    bus.start = 1'b1;
    bus.line_number = 9'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    check_i("pre_abort_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check_i("abort_busy", int'(bus.busy), 0);
    check_i("abort_done", int'(bus.done), 0);
    check_i("abort_oam_a", int'(bus.oam_a), 0);
    check_i("abort_hc", int'(bus.hit_count), 0);
    check_i("abort_ovf", int'(bus.overflow), 0);
    check_sa("abort_slots", bus.second_array, '0);
    @(negedge clk);
    rst = 1'b0;
    run_scan(100, -1, lat);
    check_i("restart_lat", lat, 259);
    check_i("restart_slot1", int'(bus.second_array[1]), 'h013);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
